// File: rtl/reg_dump_tx.sv
// Streams every register of a register file out of a UART (8N1), MSB byte first.
// Optional REG_DUMP_HEADER_EN prefixes each register with a byte holding its index.
module reg_dump_tx #(
    parameter int DATA_WIDTH   = 32,
    parameter int ADDR_WIDTH   = 5,
    parameter int CLKS_PER_BIT = 434
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    output logic [ADDR_WIDTH-1:0] rd_addr,
    input  logic [DATA_WIDTH-1:0] rd_data,
    output logic                  tx,
    output logic                  busy,
    output logic                  done
);

    // state     | meaning
    // IDLE      | line idle, waiting for start
    // LOAD      | capture rd_data into the shift register
    // START_BIT | start bit (0) of the current byte
    // DATA_BITS | eight data bits, LSB first
    // STOP_BIT  | stop bit (1); picks next byte, next register or finishes
    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        LOAD      = 3'd1,
        START_BIT = 3'd2,
        DATA_BITS = 3'd3,
        STOP_BIT  = 3'd4
    } state_t;

    localparam int DATA_BYTES = DATA_WIDTH / 8;
`ifdef REG_DUMP_HEADER_EN
    localparam bit HDR_EN      = 1'b1;
    localparam int FRAME_BYTES = DATA_BYTES + 1;
`else
    localparam bit HDR_EN      = 1'b0;
    localparam int FRAME_BYTES = DATA_BYTES;
`endif
    localparam int BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int BYTE_W = $clog2(FRAME_BYTES + 1);

    localparam logic [BAUD_W-1:0]     BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [BYTE_W-1:0]     BYTE_LAST = BYTE_W'(FRAME_BYTES - 1);
    localparam logic [ADDR_WIDTH-1:0] ADDR_LAST = '1;

    state_t                  state_q, state_d;
    logic [BAUD_W-1:0]       baud_q, baud_d;
    logic [2:0]              bit_q, bit_d;
    logic [BYTE_W-1:0]       byte_q, byte_d;
    logic [DATA_WIDTH-1:0]   shift_q, shift_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic                    busy_q, busy_d;
    logic                    fin_q, fin_d;
    logic                    done_q, done_d;
    logic                    tx_q, tx_d;

    logic                    bit_end;
    logic                    hdr_slot;
    logic [7:0]              cur_byte;

    assign bit_end  = (baud_q == BAUD_LAST);
    assign hdr_slot = HDR_EN && (byte_q == '0);

    always_comb begin
        cur_byte = shift_q[DATA_WIDTH-1 -: 8];
        if (hdr_slot) begin
            cur_byte = 8'(addr_q);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            baud_q  <= '0;
            bit_q   <= '0;
            byte_q  <= '0;
            shift_q <= '0;
            addr_q  <= '0;
            busy_q  <= 1'b0;
            fin_q   <= 1'b0;
            done_q  <= 1'b0;
            tx_q    <= 1'b1;
        end else begin
            state_q <= state_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            byte_q  <= byte_d;
            shift_q <= shift_d;
            addr_q  <= addr_d;
            busy_q  <= busy_d;
            fin_q   <= fin_d;
            done_q  <= done_d;
            tx_q    <= tx_d;
        end
    end

    always_comb begin
        state_d = state_q;
        baud_d  = baud_q;
        bit_d   = bit_q;
        byte_d  = byte_q;
        shift_d = shift_q;
        addr_d  = addr_q;
        busy_d  = busy_q;
        fin_d   = 1'b0;
        done_d  = fin_q;

        case (state_q)
            IDLE: begin
                baud_d = '0;
                bit_d  = '0;
                byte_d = '0;
                // Blocked while the finish/done pulse is still in flight.
                if (start && !fin_q && !done_q) begin
                    addr_d  = '0;
                    busy_d  = 1'b1;
                    state_d = LOAD;
                end
            end
            LOAD: begin
                shift_d = rd_data;
                byte_d  = '0;
                bit_d   = '0;
                baud_d  = '0;
                state_d = START_BIT;
            end
            START_BIT: begin
                if (bit_end) begin
                    baud_d  = '0;
                    bit_d   = '0;
                    state_d = DATA_BITS;
                end else begin
                    baud_d = baud_q + BAUD_W'(1);
                end
            end
            DATA_BITS: begin
                if (bit_end) begin
                    baud_d = '0;
                    if (bit_q == 3'd7) begin
                        state_d = STOP_BIT;
                    end else begin
                        bit_d = bit_q + 3'd1;
                    end
                end else begin
                    baud_d = baud_q + BAUD_W'(1);
                end
            end
            STOP_BIT: begin
                if (bit_end) begin
                    baud_d = '0;
                    bit_d  = '0;
                    if (byte_q == BYTE_LAST) begin
                        byte_d = '0;
                        if (addr_q == ADDR_LAST) begin
                            addr_d  = '0;
                            fin_d   = 1'b1;
                            state_d = IDLE;
                        end else begin
                            addr_d  = addr_q + ADDR_WIDTH'(1);
                            state_d = LOAD;
                        end
                    end else begin
                        if (!hdr_slot) begin
                            shift_d = shift_q << 8;
                        end
                        byte_d  = byte_q + BYTE_W'(1);
                        state_d = START_BIT;
                    end
                end else begin
                    baud_d = baud_q + BAUD_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (fin_q) begin
            busy_d = 1'b0;
        end
    end

    // The line lags the FSM by one cycle, so tx mirrors the previous state.
    always_comb begin
        tx_d = 1'b1;
        case (state_q)
            START_BIT: tx_d = 1'b0;
            DATA_BITS: tx_d = cur_byte[bit_q];
            default:   tx_d = 1'b1;
        endcase
    end

    assign rd_addr = addr_q;
    assign tx      = tx_q;
    assign busy    = busy_q;
    assign done    = done_q;

endmodule

// File: tb/tb_reg_dump_tx.sv
// Directed bench for reg_dump_tx: decodes the UART line and checks bytes, framing and timing.
module tb_reg_dump_tx;

    localparam int DW  = 32;
    localparam int AW  = 5;
    localparam int CPB = 4;
`ifdef REG_DUMP_HEADER_EN
    localparam int NB  = 5;
    localparam int HDR = 1;
`else
    localparam int NB  = 4;
    localparam int HDR = 0;
`endif
    localparam int BYTES_TOTAL = 32 * NB;
    localparam int DONE_N      = 32 * (NB * 10 * CPB + 1) + 1;

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic [AW-1:0] rd_addr;
    logic [DW-1:0] rd_data;
    logic          tx;
    logic          busy;
    logic          done;

    logic [DW-1:0] regs [32];
    assign rd_data = regs[rd_addr];

    int errors;
    int checks;

    always #5 clk = ~clk;

    reg_dump_tx #(
        .DATA_WIDTH  (DW),
        .ADDR_WIDTH  (AW),
        .CLKS_PER_BIT(CPB)
    ) dut (
        .clk    (clk),
        .reset  (reset),
        .start  (start),
        .rd_addr(rd_addr),
        .rd_data(rd_data),
        .tx     (tx),
        .busy   (busy),
        .done   (done)
    );

    // UART receiver sampling mid-bit on falling edges.
    logic [7:0] rx_q [$];
    logic [7:0] rx_sh;
    logic       rx_act = 1'b0;
    int         rx_cnt = 0;
    int         frame_err = 0;

    always @(negedge clk) begin
        if (reset !== 1'b1) begin
            rx_act <= 1'b0;
            rx_cnt <= 0;
        end else if (!rx_act) begin
            if (tx === 1'b0) begin
                rx_act <= 1'b1;
                rx_cnt <= 0;
            end
        end else begin
            rx_cnt <= rx_cnt + 1;
            if (rx_cnt + 1 >= CPB + CPB / 2 && rx_cnt + 1 <= 8 * CPB + CPB / 2 &&
                ((rx_cnt + 1 - CPB - CPB / 2) % CPB) == 0) begin
                rx_sh[3'((rx_cnt + 1 - CPB - CPB / 2) / CPB)] <= tx;
            end
            if (rx_cnt + 1 == 9 * CPB + CPB / 2) begin
                if (tx !== 1'b1) frame_err <= frame_err + 1;
                rx_q.push_back(rx_sh);
            end
            if (rx_cnt + 1 == 10 * CPB - 1) rx_act <= 1'b0;
        end
    end

    function automatic logic [7:0] exp_byte(input int idx);
        int r;
        int b;
        logic [DW-1:0] w;
        r = idx / NB;
        b = idx % NB;
        if (HDR == 1 && b == 0) return 8'(r);
        w = regs[r] >> (8 * (NB - 1 - b));
        return w[7:0];
    endfunction

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic abort_dump();
        @(negedge clk);
        reset = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        rx_q.delete();
    endtask

    task automatic run_to_done(input int n_start, input int limit,
                               output int n_done, output int busy_bad);
        int n;
        n = n_start;
        n_done = -1;
        busy_bad = 0;
        while (n < limit) begin
            @(posedge clk);
            #1;
            n++;
            if (done === 1'b1) begin
                n_done = n;
                break;
            end
            if (busy !== 1'b1) busy_bad++;
        end
    endtask

    task automatic test_reset();
        int bad;
        reset = 1'b0;
        start = 1'b1;
        repeat (3) @(negedge clk);
        checks++; if (tx !== 1'b1)   begin errors++; $display("FAIL reset_tx: got %b want 1", tx); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", done); end
        checks++; if (rd_addr !== '0) begin errors++; $display("FAIL reset_addr: got %0d want 0", rd_addr); end
        start = 1'b0;
        reset = 1'b1;
        bad = 0;
        repeat (100) begin
            @(negedge clk);
            if (tx !== 1'b1 || busy !== 1'b0 || done !== 1'b0 || rd_addr !== '0) bad++;
        end
        checks++; if (bad != 0) begin errors++; $display("FAIL idle_hold: %0d bad cycles, want 0", bad); end
        checks++; if (rx_q.size() != 0) begin errors++; $display("FAIL idle_bytes: got %0d want 0", rx_q.size()); end
    endtask

    task automatic test_frame_timing();
        int wait_n;
        int bad_busy;
        int low_bad;
        int stop_bad;
        int base;
        logic arr [0:255];
        rx_q.delete();
        pulse_start();
        wait_n = 0;
        while (tx !== 1'b0 && wait_n < 20) begin
            @(negedge clk);
            wait_n++;
        end
        checks++; if (wait_n >= 20) begin errors++; $display("FAIL tx_fall_timeout: waited %0d want <20", wait_n); end
        bad_busy = 0;
        for (int j = 0; j <= NB * 10 * CPB; j++) begin
            arr[j] = tx;
            if (busy !== 1'b1) bad_busy++;
            @(negedge clk);
        end
        base = (NB - 4) * 10 * CPB;
        low_bad = 0;
        for (int k = 0; k < CPB; k++) if (arr[base + k] !== 1'b0) low_bad++;
        if (arr[base + CPB] !== 1'b1) low_bad++;
        checks++; if (low_bad != 0) begin errors++; $display("FAIL start_bit_len: %0d deviations want 0", low_bad); end
        stop_bad = 0;
        if (arr[base + 9 * CPB - 1] !== 1'b0) stop_bad++;
        for (int k = 9 * CPB; k < 10 * CPB; k++) if (arr[base + k] !== 1'b1) stop_bad++;
        if (arr[base + 10 * CPB] !== 1'b0) stop_bad++;
        checks++; if (stop_bad != 0) begin errors++; $display("FAIL stop_bit_len: %0d deviations want 0", stop_bad); end
        checks++; if (bad_busy != 0) begin errors++; $display("FAIL frame_busy: %0d low cycles want 0", bad_busy); end
        abort_dump();
    endtask

    task automatic test_dump();
        int n_done;
        int busy_bad;
        int done_cnt;
        int mis;
        rx_q.delete();
        frame_err = 0;
        pulse_start();
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL busy_after_start: got %b want 1", busy); end
        @(posedge clk); #1;
        checks++; if (tx !== 1'b1) begin errors++; $display("FAIL tx_load_cycle: got %b want 1", tx); end
        @(posedge clk); #1;
        checks++; if (tx !== 1'b0) begin errors++; $display("FAIL tx_fall_edge2: got %b want 0", tx); end
        run_to_done(2, 7000, n_done, busy_bad);
        checks++; if (n_done != DONE_N) begin errors++; $display("FAIL done_time: got %0d want %0d", n_done, DONE_N); end
        checks++; if (busy_bad != 0) begin errors++; $display("FAIL busy_during_dump: %0d low cycles want 0", busy_bad); end
        checks++; if (busy !== 1'b0 || rd_addr !== '0) begin
            errors++; $display("FAIL end_state: busy=%b addr=%0d want 0/0", busy, rd_addr);
        end
        done_cnt = (done === 1'b1) ? 1 : 0;
        repeat (20) begin
            @(posedge clk); #1;
            if (done === 1'b1) done_cnt++;
        end
        checks++; if (done_cnt != 1) begin errors++; $display("FAIL done_pulses: got %0d want 1", done_cnt); end
        checks++; if (rx_q.size() != BYTES_TOTAL) begin errors++; $display("FAIL byte_count: got %0d want %0d", rx_q.size(), BYTES_TOTAL); end
`ifdef REG_DUMP_HEADER_EN
        checks++; if (rx_q[10] !== 8'h02 || rx_q[11] !== 8'h12 || rx_q[12] !== 8'h34 ||
                      rx_q[13] !== 8'h56 || rx_q[14] !== 8'h78) begin
            errors++; $display("FAIL x2_bytes: got %h %h %h %h %h want 02 12 34 56 78",
                               rx_q[10], rx_q[11], rx_q[12], rx_q[13], rx_q[14]);
        end
`else
        checks++; if (rx_q[4] !== 8'hDE || rx_q[5] !== 8'hAD || rx_q[6] !== 8'hBE || rx_q[7] !== 8'hEF) begin
            errors++; $display("FAIL x1_bytes: got %h %h %h %h want de ad be ef", rx_q[4], rx_q[5], rx_q[6], rx_q[7]);
        end
`endif
        mis = 0;
        foreach (rx_q[i]) if (rx_q[i] !== exp_byte(i)) mis++;
        checks++; if (mis != 0) begin errors++; $display("FAIL stream: %0d wrong bytes want 0", mis); end
        checks++; if (frame_err != 0) begin errors++; $display("FAIL framing: %0d bad stop bits want 0", frame_err); end
    endtask

    task automatic test_back_to_back();
        int n;
        int n_done;
        int busy_bad;
        int mis;
        rx_q.delete();
        pulse_start();
        n = 0;
        while (rx_q.size() < 10 && n < 3000) begin
            @(posedge clk); #1;
            n++;
        end
        checks++; if (rx_q.size() < 10) begin errors++; $display("FAIL b2b_reach10: got %0d bytes want 10", rx_q.size()); end
        start = 1'b1;
        @(posedge clk); #1;
        n++;
        start = 1'b0;
        run_to_done(n, 7000, n_done, busy_bad);
        checks++; if (n_done != DONE_N) begin errors++; $display("FAIL b2b_done_time: got %0d want %0d", n_done, DONE_N); end
        mis = (rx_q.size() == BYTES_TOTAL) ? 0 : 1;
        foreach (rx_q[i]) if (rx_q[i] !== exp_byte(i)) mis++;
        checks++; if (mis != 0) begin errors++; $display("FAIL b2b_stream: %0d errors want 0 (size %0d)", mis, rx_q.size()); end
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL start_during_done: busy=%b want 0", busy); end
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL start_after_done: busy=%b want 1", busy); end
        abort_dump();
    endtask

    task automatic test_reset_mid_frame();
        int n;
        int r;
        int b;
        int s;
        int bad;
        logic [7:0] eb;
        rx_q.delete();
        pulse_start();
        n = 0;
        r = 20 / NB;
        b = 20 % NB;
        s = 1 + r * (NB * 10 * CPB + 1) + b * 10 * CPB;
        while (n < s + 17) begin
            @(posedge clk); #1;
            n++;
        end
        eb = exp_byte(20);
        checks++; if (tx !== eb[3]) begin errors++; $display("FAIL mid_bit3: got %b want %b", tx, eb[3]); end
        #1 reset = 1'b0;
        #1;
        checks++; if (tx !== 1'b1 || busy !== 1'b0) begin
            errors++; $display("FAIL abort_outputs: tx=%b busy=%b want 1/0", tx, busy);
        end
        checks++; if (rd_addr !== '0 || done !== 1'b0) begin
            errors++; $display("FAIL abort_addr: addr=%0d done=%b want 0/0", rd_addr, done);
        end
        repeat (2) @(negedge clk);
        reset = 1'b1;
        rx_q.delete();
        bad = 0;
        repeat (30) begin
            @(negedge clk);
            if (busy !== 1'b0 || tx !== 1'b1) bad++;
        end
        checks++; if (bad != 0 || rx_q.size() != 0) begin
            errors++; $display("FAIL no_auto_restart: %0d bad cycles, %0d bytes want 0/0", bad, rx_q.size());
        end
        pulse_start();
        n = 0;
        while (rx_q.size() < 1 && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        checks++; if (rx_q.size() < 1 || rx_q[0] !== exp_byte(0)) begin
            errors++; $display("FAIL restart_first_byte: got %h (n=%0d) want %h", rx_q[0], rx_q.size(), exp_byte(0));
        end
        abort_dump();
    endtask

    initial begin
        errors = 0;
        checks = 0;
        start  = 1'b0;
        reset  = 1'b0;
        for (int i = 0; i < 32; i++) regs[i] = 32'(i * 32'h01010101) ^ 32'hA5C30F96;
        regs[0] = 32'h55B2C3D4;
        regs[1] = 32'hDEADBEEF;
        regs[2] = 32'h12345678;
        regs[5] = 32'h60A1B2C3;
        test_reset();
        test_frame_timing();
        test_dump();
        test_back_to_back();
        test_reset_mid_frame();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
